logic_gate_checker: RTL and testbench

//  Self-checking stimulus/checker stage wrapped around the two-input logic-gate block.

---
 rtl/logic_gate_checker.sv | 158 +++++++++++++++
 tb/tb_logic_gate_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_checker.sv
// -----------------------------------------------------------------------------
// logic_gate_checker
//   Stimulus generator and checker wrapped around a two-input logic-gate block.
//   A run walks a/b through the truth table 00,01,10,11 for ROUNDS passes,
//   holds each vector for SETTLE_CYCLES edges, then samples the six gate
//   outputs on one SAMPLE edge and scores them against golden values.
//
// Parameters
//   SETTLE_CYCLES  edges a/b are held before sampling (>=1)
//   ROUNDS         full truth-table passes per run (>=1)
//   ERR_W          width of err_count; the count saturates at 2^ERR_W-1
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          launches a run; only looked at in IDLE
//   a_out, b_out   stimulus to the gate block (vec_idx[1], vec_idx[0])
//   *_in           gate block outputs: AND, OR, NOT(~a), NAND, NOR, XOR
//   vec_idx        current truth-table vector
//   busy           high from the start edge until DONE
//   done           one-cycle pulse at the end of a run
//   pass           err_count==0 at end of run, held until the next start
//   err_count      total mismatching output bits, saturating
//   fail_mask      sticky per-gate fail [0]AND [1]OR [2]NOT [3]NAND [4]NOR [5]XOR
// -----------------------------------------------------------------------------
module logic_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             xor_in,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [5:0]       fail_mask
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  // Three spare bits hold the sum of a saturated count plus up to six new
  // mismatches without overflowing, so the clamp decision is exact.
  localparam int SUM_W = ERR_W + 3;
  localparam logic [SUM_W-1:0] ERR_MAX = {3'b000, {ERR_W{1'b1}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic [RND_W-1:0] round;

  logic [5:0]       golden;
  logic [5:0]       observed;
  logic [5:0]       mismatch;
  logic [2:0]       mis_count;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_next;

  // Stimulus comes straight from the registered vector index.
  assign a_out = vec_idx[1];
  assign b_out = vec_idx[0];

  // NOTE: every signal driven here gets a value before any conditional use,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    golden    = {a_out ^ b_out, ~(a_out | b_out), ~(a_out & b_out),
                 ~a_out, a_out | b_out, a_out & b_out};
    observed  = {xor_in, nor_in, nand_in, not_in, or_in, and_in};
    mismatch  = golden ^ observed;
    mis_count = '0;
    for (int i = 0; i < 6; i++) begin
      mis_count = mis_count + 3'(mismatch[i]);
    end
    err_sum  = {3'b000, err_count} + SUM_W'(mis_count);
    err_next = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop in this
  // block sees the pre-edge values of the others, independent of ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      round      <= '0;
      vec_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            round      <= '0;
            vec_idx    <= '0;
            err_count  <= '0;
            fail_mask  <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          fail_mask <= fail_mask | mismatch;
          if (vec_idx == 2'd3 && round == RND_LAST) begin
            // Result flags are loaded on entry so they are visible during
            // the single DONE cycle alongside the done pulse.
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
          end else begin
            vec_idx <= vec_idx + 2'd1;
            if (vec_idx == 2'd3) begin
              round <= round + 1'b1;
            end
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_checker
//   Two checker instances (S=2/R=1/ERR_W=8 and S=2/R=2/ERR_W=2) each drive a
//   behavioural gate block with injectable faults: per-vector output flips
//   plus stuck-at-0 / stuck-at-1 masks. Expected err_count/fail_mask come
//   from the fault tables, and timing/vector sequencing from the run length.
// -----------------------------------------------------------------------------
module tb_logic_gate_checker;

  localparam int S  = 2;
  localparam int R0 = 1;
  localparam int R1 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [2];
  logic       a_w     [2];
  logic       b_w     [2];
  logic [1:0] vec_w   [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [5:0] mask_w  [2];
  logic [5:0] gin     [2];
  logic [7:0] err0;
  logic [1:0] err1;

  logic [5:0] flip [2][4];
  logic [5:0] st0  [2];
  logic [5:0] st1  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Truth of the six gates, ordered {XOR, NOR, NAND, NOT, OR, AND}.
  function automatic logic [5:0] ideal(input logic a, input logic b);
    return {a ^ b, !(a | b), !(a & b), !a, a | b, a & b};
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      gin[d] = ((ideal(a_w[d], b_w[d]) ^ flip[d][{a_w[d], b_w[d]}]) & ~st0[d]) | st1[d];
    end
  end

  logic_gate_checker #(.SETTLE_CYCLES(S), .ROUNDS(R0), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .a_out(a_w[0]), .b_out(b_w[0]),
    .and_in(gin[0][0]), .or_in(gin[0][1]), .not_in(gin[0][2]),
    .nand_in(gin[0][3]), .nor_in(gin[0][4]), .xor_in(gin[0][5]),
    .vec_idx(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err0), .fail_mask(mask_w[0])
  );

  logic_gate_checker #(.SETTLE_CYCLES(S), .ROUNDS(R1), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .a_out(a_w[1]), .b_out(b_w[1]),
    .and_in(gin[1][0]), .or_in(gin[1][1]), .not_in(gin[1][2]),
    .nand_in(gin[1][3]), .nor_in(gin[1][4]), .xor_in(gin[1][5]),
    .vec_idx(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err1), .fail_mask(mask_w[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int err_of(input int d);
    return (d == 0) ? int'(err0) : int'(err1);
  endfunction

  // Expected totals: every round sees the same faulty outputs, so the raw
  // count is rounds * mismatching bits over the four vectors, then clamped.
  task automatic model(input int d, output int e, output int m);
    int         rounds = (d == 0) ? R0 : R1;
    int         emax   = (d == 0) ? 255 : 3;
    int         total  = 0;
    logic [5:0] mm     = '0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv  = 2'(v);
      logic [5:0] id  = ideal(vv[1], vv[0]);
      logic [5:0] drv = ((id ^ flip[d][v]) & ~st0[d]) | st1[d];
      total += rounds * $countones(drv ^ id);
      mm    |= drv ^ id;
    end
    e = (total > emax) ? emax : total;
    m = int'(mm);
  endtask

  task automatic check_final(input string tag, input int d, input int e, input int m);
    check({tag, "/pass"}, int'(pass_w[d]), int'(e == 0));
    check({tag, "/err"},  err_of(d), e);
    check({tag, "/mask"}, int'(mask_w[d]), m);
  endtask

  task automatic check_cleared(input string tag, input int d);
    check({tag, "/busy0"}, int'(busy_w[d]), 1);
    check({tag, "/vec0"},  int'(vec_w[d]), 0);
    check({tag, "/err0"},  err_of(d), 0);
    check({tag, "/mask0"}, int'(mask_w[d]), 0);
    check({tag, "/pass0"}, int'(pass_w[d]), 0);
  endtask

  // One complete run; optional stray start pulse while busy/DONE, or start
  // held high through DONE to exercise the back-to-back relaunch.
  task automatic run(input string tag, input int d, input bit repulse, input bit hold);
    int n  = 4 * ((d == 0) ? R0 : R1) * (S + 1);
    int rk = repulse ? int'($urandom_range(1, n + 1)) : -1;
    int e, m;
    model(d, e, m);
    @(negedge clk); start_s[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold) start_s[d] = 1'b0;
    check_cleared(tag, d);
    for (int k = 1; k <= n + 1; k++) begin
      if (!hold) start_s[d] = (k == rk);
      @(posedge clk); @(negedge clk);
      if (k < n) begin
        check({tag, "/vec"},  int'(vec_w[d]), (k / (S + 1)) % 4);
        check({tag, "/busy"}, int'(busy_w[d]), 1);
        check({tag, "/done"}, int'(done_w[d]), 0);
      end else begin
        check({tag, "/done_end"}, int'(done_w[d]), int'(k == n));
        check({tag, "/busy_end"}, int'(busy_w[d]), 0);
        check_final(tag, d, e, m);
      end
    end
    if (!hold) start_s[d] = 1'b0;
    if (hold) begin
      @(posedge clk); @(negedge clk);
      start_s[d] = 1'b0;
      check_cleared({tag, "/relaunch"}, d);
      repeat (n) @(posedge clk);
      @(negedge clk);
      check({tag, "/relaunch_done"}, int'(done_w[d]), 1);
      check_final({tag, "/relaunch"}, d, e, m);
      @(posedge clk); @(negedge clk);
      check({tag, "/relaunch_idle"}, int'(done_w[d]), 0);
    end
  endtask

  task automatic clear_faults();
    for (int d = 0; d < 2; d++) begin
      st0[d] = '0;
      st1[d] = '0;
      for (int v = 0; v < 4; v++) flip[d][v] = '0;
    end
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    clear_faults();

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst/vec",  int'(vec_w[d]), 0);
      check("rst/busy", int'(busy_w[d]), 0);
      check("rst/done", int'(done_w[d]), 0);
      check("rst/pass", int'(pass_w[d]), 0);
      check("rst/err",  err_of(d), 0);
      check("rst/mask", int'(mask_w[d]), 0);
    end
    rst_n = 1'b1;

    // T1: ideal gates.
    run("T1", 0, 1'b0, 1'b0);

    // T2: XOR stuck at 0.
    st0[0] = 6'b100000;
    run("T2", 0, 1'b0, 1'b0);
    clear_faults();

    // T3: NAND output wired to AND.
    for (int v = 0; v < 4; v++) flip[0][v] = 6'b001000;
    run("T3", 0, 1'b0, 1'b0);
    clear_faults();

    // T4: every output stuck at 0 on the narrow-counter instance.
    st0[1] = 6'b111111;
    run("T4", 1, 1'b0, 1'b0);
    clear_faults();

    // T5: reset during SETTLE of vector 2, with a fault so counters are nonzero.
    st0[0] = 6'b100000;
    @(negedge clk); start_s[0] = 1'b1;
    @(posedge clk); @(negedge clk); start_s[0] = 1'b0;
    repeat (2 * (S + 1) + 1) @(posedge clk);
    @(negedge clk);
    check("T5/vec_pre",  int'(vec_w[0]), 2);
    check("T5/err_pre",  err_of(0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("T5/vec_rst",  int'(vec_w[0]), 0);
    check("T5/busy_rst", int'(busy_w[0]), 0);
    check("T5/err_rst",  err_of(0), 0);
    check("T5/mask_rst", int'(mask_w[0]), 0);
    check("T5/pass_rst", int'(pass_w[0]), 0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0]) done_seen++;
    end
    check("T5/no_done", done_seen, 0);
    check("T5/idle",    int'(busy_w[0]), 0);
    clear_faults();
    run("T5b", 0, 1'b0, 1'b0);

    // T6: stray start while busy, then start held through DONE with a fault
    // so the relaunch clear of err_count is observable.
    run("T6a", 0, 1'b1, 1'b0);
    st0[0] = 6'b100000;
    run("T6b", 0, 1'b0, 1'b1);
    clear_faults();

    // Randomized fault patterns on either instance.
    for (int it = 0; it < 8; it++) begin
      int d = int'($urandom_range(0, 1));
      for (int v = 0; v < 4; v++) flip[d][v] = 6'($urandom & $urandom & $urandom);
      st0[d] = 6'($urandom & $urandom & $urandom);
      st1[d] = 6'($urandom & $urandom & $urandom) & ~st0[d];
      run($sformatf("R%0d", it), d, 1'($urandom_range(0, 1)), 1'b0);
      clear_faults();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
